uart_bus_bridge: RTL and testbench

- Debug bus initiator that drives the same memory-mapped peripheral/data bus the MEM stage answers (TH/TL/TCON/leds/digit/Systick at 0x4000_00xx, RAM, ROM at 0x3xxx_xxxx).
- Receives 8N1 serial commands, requests the bus from the pipeline, and performs one single-cycle read or write.
- Serialises the result back to the host.
- Sits at top level beside the CPU; a top-level mux gives the bridge's address/data/strobes priority while `bus_gnt` is high.

---
 rtl/uart_bus_bridge_pkg.sv | 36 +++
 rtl/uart_byte_io.sv | 149 ++++++++++++++
 rtl/uart_bus_bridge.sv | 151 +++++++++++++++
 tb/tb_uart_bus_bridge.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_bus_bridge_pkg.sv
// rtl/uart_bus_bridge_pkg.sv - shared command bytes, FSM encoding and peripheral addresses
package uart_bus_bridge_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RSP_OK    = 8'h4B;

    localparam logic [31:0] ADDR_TH      = 32'h4000_0000;
    localparam logic [31:0] ADDR_TL      = 32'h4000_0004;
    localparam logic [31:0] ADDR_TCON    = 32'h4000_0008;
    localparam logic [31:0] ADDR_LEDS    = 32'h4000_000C;
    localparam logic [31:0] ADDR_DIGIT   = 32'h4000_0010;
    localparam logic [31:0] ADDR_SYSTICK = 32'h4000_0014;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_REQ,
        ST_ACC,
        ST_RESP
    } state_t;

    // Byte idx of a word, most significant byte first (idx 0 = bits 31:24).
    function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_byte_io.sv
// rtl/uart_byte_io.sv - 8N1 receive and transmit engines sharing one bit period
module uart_byte_io #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_i,
    output logic       tx_o,
    output logic       rx_valid_o,
    output logic [7:0] rx_byte_o,
    input  logic       tx_start_i,
    input  logic [7:0] tx_byte_i,
    output logic       tx_busy_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t       rx_state_q, rx_state_d;
    logic            rx_meta_q, rx_sync_q, rx_prev_q;
    logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic            rx_valid_q, rx_valid_d;

    logic            tx_busy_q, tx_busy_d;
    logic            tx_q, tx_d;
    logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
    logic [3:0]      tx_bit_q, tx_bit_d;
    logic [8:0]      tx_shift_q, tx_shift_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_valid_q <= 1'b0;
            tx_busy_q  <= 1'b0;
            tx_q       <= 1'b1;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '1;
        end else begin
            rx_meta_q  <= rx_i;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_valid_q <= rx_valid_d;
            tx_busy_q  <= tx_busy_d;
            tx_q       <= tx_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
        end
    end

    // Start bit is confirmed half a bit after the falling edge; later samples land mid-bit.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_valid_d = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                end
            end
            RX_START: begin
                if (rx_cnt_q == HALF) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 1'b1;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == LAST) begin
                    rx_state_d = RX_IDLE;
                    rx_valid_d = rx_sync_q;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Frame is start, 8 data bits, stop; tx_bit_q counts completed bit periods.
    always_comb begin
        tx_busy_d  = tx_busy_q;
        tx_d       = tx_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        if (!tx_busy_q) begin
            if (tx_start_i) begin
                tx_busy_d  = 1'b1;
                tx_d       = 1'b0;
                tx_cnt_d   = '0;
                tx_bit_d   = '0;
                tx_shift_d = {1'b1, tx_byte_i};
            end
        end else if (tx_cnt_q == LAST) begin
            tx_cnt_d = '0;
            if (tx_bit_q == 4'd9) begin
                tx_busy_d = 1'b0;
                tx_d      = 1'b1;
            end else begin
                tx_d       = tx_shift_q[0];
                tx_shift_d = {1'b1, tx_shift_q[8:1]};
                tx_bit_d   = tx_bit_q + 1'b1;
            end
        end else begin
            tx_cnt_d = tx_cnt_q + 1'b1;
        end
    end

    assign rx_valid_o = rx_valid_q;
    assign rx_byte_o  = rx_shift_q;
    assign tx_o       = tx_q;
    assign tx_busy_o  = tx_busy_q;

endmodule

// File: rtl/uart_bus_bridge.sv
// rtl/uart_bus_bridge.sv - serial command parser that owns the memory bus for one access
module uart_bus_bridge
    import uart_bus_bridge_pkg::*;
#(
    parameter int CLKS_PER_BIT   = 868,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        bus_read,
    output logic        bus_write,
    input  logic [31:0] bus_rdata,
    output logic        busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       tx_start;
    logic [7:0] tx_byte;
    logic       tx_busy;

    state_t        state_q, state_d;
    logic          op_write_q, op_write_d;
    logic [1:0]    byte_cnt_q, byte_cnt_d;
    logic [1:0]    resp_cnt_q, resp_cnt_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;

    uart_byte_io #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_io (
        .clk        (clk),
        .reset      (reset),
        .rx_i       (uart_rx),
        .tx_o       (uart_tx),
        .rx_valid_o (rx_valid),
        .rx_byte_o  (rx_byte),
        .tx_start_i (tx_start),
        .tx_byte_i  (tx_byte),
        .tx_busy_o  (tx_busy)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            op_write_q <= 1'b0;
            byte_cnt_q <= '0;
            resp_cnt_q <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            to_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            op_write_q <= op_write_d;
            byte_cnt_q <= byte_cnt_d;
            resp_cnt_q <= resp_cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_write_d = op_write_q;
        byte_cnt_d = byte_cnt_q;
        resp_cnt_d = resp_cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        to_cnt_d   = to_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (rx_valid && (rx_byte == CMD_WRITE || rx_byte == CMD_READ)) begin
                    op_write_d = (rx_byte == CMD_WRITE);
                    byte_cnt_d = '0;
                    to_cnt_d   = '0;
                    state_d    = ST_ADDR;
                end
            end
            ST_ADDR, ST_DATA: begin
                if (rx_valid) begin
                    to_cnt_d   = '0;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (state_q == ST_ADDR) begin
                        addr_d = {addr_q[23:0], rx_byte};
                    end else begin
                        wdata_d = {wdata_q[23:0], rx_byte};
                    end
                    if (byte_cnt_q == 2'd3) begin
                        state_d = (state_q == ST_ADDR && op_write_q) ? ST_DATA : ST_REQ;
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            ST_REQ: begin
                if (bus_gnt) begin
                    state_d = ST_ACC;
                end
            end
            // A grant withdrawn in the access cycle sends us back to wait rather than strobe.
            ST_ACC: begin
                if (bus_gnt) begin
                    if (!op_write_q) begin
                        rdata_d = bus_rdata;
                    end
                    resp_cnt_d = '0;
                    state_d    = ST_RESP;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_RESP: begin
                if (!tx_busy) begin
                    resp_cnt_d = resp_cnt_q + 2'd1;
                    if (op_write_q || resp_cnt_q == 2'd3) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus_req   = (state_q == ST_REQ) || (state_q == ST_ACC);
        bus_read  = (state_q == ST_ACC) && bus_gnt && !op_write_q;
        bus_write = (state_q == ST_ACC) && bus_gnt && op_write_q;
        busy      = (state_q != ST_IDLE);
        tx_start  = (state_q == ST_RESP) && !tx_busy;
        tx_byte   = op_write_q ? RSP_OK : word_byte(rdata_q, resp_cnt_q);
    end

    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_uart_bus_bridge.sv
// tb/tb_uart_bus_bridge.sv - directed serial commands checked against a transaction-level model
module tb_uart_bus_bridge;
    import uart_bus_bridge_pkg::*;

    localparam int CPB = 8;
    localparam int TMO = 500;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        uart_rx = 1'b1;
    logic        uart_tx;
    logic        bus_req;
    logic        bus_gnt = 1'b1;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_read;
    logic        bus_write;
    logic [31:0] bus_rdata;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        wr;
    } acc_t;

    acc_t       exp_acc[$];
    logic [7:0] exp_tx[$];

    int          strobes = 0;
    int          strobe_cyc = 0;
    int          tx_count = 0;
    logic [31:0] last_addr = '0;
    logic [31:0] last_wdata = '0;
    logic        last_wr = 1'b0;
    logic [7:0]  last_tx = '0;
    logic [31:0] tx_hist = '0;

    function automatic logic [31:0] rdata_for(input logic [31:0] a);
        return (a == 32'h4000_0014) ? 32'h1234_5678 : (a ^ 32'hA5A5_A5A5);
    endfunction

    assign bus_rdata = bus_read ? rdata_for(bus_addr) : 32'hDEAD_BEEF;

    uart_bus_bridge #(.CLKS_PER_BIT(CPB), .TIMEOUT_CYCLES(TMO)) dut (
        .clk       (clk),
        .reset     (reset),
        .uart_rx   (uart_rx),
        .uart_tx   (uart_tx),
        .bus_req   (bus_req),
        .bus_gnt   (bus_gnt),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_read  (bus_read),
        .bus_write (bus_write),
        .bus_rdata (bus_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin : cycle_counter
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic model_write(input logic [31:0] a, input logic [31:0] d);
        exp_acc.push_back('{a, d, 1'b1});
        exp_tx.push_back(8'h4B);
    endtask

    task automatic model_read(input logic [31:0] a);
        logic [31:0] w;
        w = rdata_for(a);
        exp_acc.push_back('{a, 32'h0, 1'b0});
        for (int i = 3; i >= 0; i--) begin
            exp_tx.push_back(8'(w >> (8 * i)));
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(posedge clk);
        #1;
        uart_rx = 1'b0;
        repeat (CPB) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        uart_rx = stop;
        repeat (CPB) @(posedge clk);
        #1;
        uart_rx = 1'b1;
        repeat (CPB) @(posedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) begin
            send_byte(8'(w >> (8 * i)), 1'b1);
        end
    endtask

    task automatic send_write(input logic [31:0] a, input logic [31:0] d);
        send_byte(8'h57, 1'b1);
        send_word(a);
        send_word(d);
    endtask

    task automatic send_read(input logic [31:0] a);
        send_byte(8'h52, 1'b1);
        send_word(a);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((exp_acc.size() != 0 || exp_tx.size() != 0 || busy) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_completes"}, 32'(n < 4000), 32'd1);
        exp_acc.delete();
        exp_tx.delete();
        repeat (20) @(negedge clk);
    endtask

    task automatic wait_req(input string name);
        int n;
        n = 0;
        while (!bus_req && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_req_seen"}, 32'(bus_req), 32'd1);
    endtask

    initial begin : bus_compare
        acc_t e;
        logic after_acc;
        after_acc = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                check("strobe_legal",
                      32'((bus_read && bus_write) || ((bus_read || bus_write) && !bus_gnt)), 32'd0);
                if (after_acc) begin
                    check("req_after_acc", 32'(bus_req), 32'd0);
                end
                if (bus_read || bus_write) begin
                    strobes++;
                    strobe_cyc = cyc;
                    last_addr  = bus_addr;
                    last_wdata = bus_wdata;
                    last_wr    = bus_write;
                    check("req_during_acc", 32'(bus_req), 32'd1);
                    if (exp_acc.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_strobe: got strobe at addr %h, expected none", bus_addr);
                    end else begin
                        e = exp_acc.pop_front();
                        check("acc_kind", 32'(bus_write), 32'(e.wr));
                        check("acc_addr", bus_addr, e.addr);
                        if (e.wr) begin
                            check("acc_wdata", bus_wdata, e.data);
                        end
                    end
                end
                after_acc = bus_read || bus_write;
            end else begin
                after_acc = 1'b0;
            end
        end
    end

    initial begin : tx_monitor
        logic [7:0] b;
        logic       ok;
        forever begin
            @(negedge clk);
            if (!reset && uart_tx == 1'b0) begin
                ok = 1'b1;
                for (int k = 1; k < CPB; k++) begin
                    @(negedge clk);
                    if (uart_tx !== 1'b0) ok = 1'b0;
                end
                for (int i = 0; i < 8; i++) begin
                    @(negedge clk);
                    b[i] = uart_tx;
                    for (int k = 1; k < CPB; k++) begin
                        @(negedge clk);
                        if (uart_tx !== b[i]) ok = 1'b0;
                    end
                end
                for (int k = 0; k < CPB; k++) begin
                    @(negedge clk);
                    if (uart_tx !== 1'b1) ok = 1'b0;
                end
                tx_count++;
                last_tx = b;
                tx_hist = {tx_hist[23:0], b};
                check("tx_bit_timing", 32'(ok), 32'd1);
                if (exp_tx.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_tx: got byte %h, expected none", b);
                end else begin
                    check("tx_byte", 32'(b), 32'(exp_tx.pop_front()));
                end
            end
        end
    end

    initial begin : watchdog
        #(400_000);
        n_cmp++;
        n_bad++;
        $display("FAIL watchdog: got no end of run, expected finish within 40000 cycles");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int s0;
        int t0;
        int cnt;
        int raise_cyc;

        repeat (3) @(posedge clk);
        #1;
        check("rst_uart_tx", 32'(uart_tx), 32'd1);
        check("rst_bus_req", 32'(bus_req), 32'd0);
        check("rst_strobes", 32'(bus_read | bus_write), 32'd0);
        check("rst_bus_addr", bus_addr, 32'h0);
        check("rst_bus_wdata", bus_wdata, 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        repeat (5) @(posedge clk);

        // Write to leds with the grant tied high.
        s0 = strobes;
        model_write(ADDR_LEDS, 32'h0000_00A5);
        send_write(ADDR_LEDS, 32'h0000_00A5);
        wait_done("wr_leds");
        check("wr_leds_addr", last_addr, 32'h4000_000C);
        check("wr_leds_wdata", last_wdata, 32'h0000_00A5);
        check("wr_leds_kind", 32'(last_wr), 32'd1);
        check("wr_leds_reply", 32'(last_tx), 32'h4B);
        check("wr_leds_one_strobe", 32'(strobes - s0), 32'd1);
        check("wr_leds_busy", 32'(busy), 32'd0);

        // Read Systick.
        s0 = strobes;
        model_read(ADDR_SYSTICK);
        send_read(ADDR_SYSTICK);
        wait_done("rd_systick");
        check("rd_systick_reply", tx_hist, 32'h1234_5678);
        check("rd_systick_one_strobe", 32'(strobes - s0), 32'd1);
        check("rd_systick_kind", 32'(last_wr), 32'd0);

        // Grant withheld for 100 cycles, then raised.
        bus_gnt = 1'b0;
        s0 = strobes;
        model_read(ADDR_TL);
        send_read(ADDR_TL);
        wait_req("stall");
        cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (!bus_req) cnt++;
        end
        check("stall_req_held", 32'(cnt), 32'd0);
        check("stall_no_strobe", 32'(strobes - s0), 32'd0);
        @(posedge clk);
        #1;
        bus_gnt = 1'b1;
        raise_cyc = cyc;
        wait_done("stall");
        check("stall_strobe_cycle", 32'(strobe_cyc), 32'(raise_cyc + 1));
        check("stall_reply", tx_hist, 32'hE5A5_A5A1);

        // Garbage byte, then an abandoned command that must time out.
        s0 = strobes;
        t0 = tx_count;
        send_byte(8'h00, 1'b1);
        check("garbage_ignored", 32'(busy), 32'd0);
        send_byte(8'h57, 1'b1);
        send_byte(8'h40, 1'b1);
        check("partial_cmd_busy", 32'(busy), 32'd1);
        cnt = 0;
        repeat (600) begin
            @(negedge clk);
            if (bus_req) cnt++;
        end
        check("timeout_no_req", 32'(cnt), 32'd0);
        check("timeout_idle", 32'(busy), 32'd0);
        check("timeout_no_reply", 32'(tx_count - t0), 32'd0);
        check("timeout_no_strobe", 32'(strobes - s0), 32'd0);
        model_write(ADDR_DIGIT, 32'h0000_1234);
        send_write(ADDR_DIGIT, 32'h0000_1234);
        wait_done("after_timeout");
        check("after_timeout_addr", last_addr, 32'h4000_0010);
        check("after_timeout_wdata", last_wdata, 32'h0000_1234);

        // Framing error: command byte with a low stop bit.
        send_byte(8'h57, 1'b0);
        cnt = 0;
        repeat (60) begin
            @(negedge clk);
            if (busy) cnt++;
        end
        check("framing_discarded", 32'(cnt), 32'd0);

        // Reset while waiting for the grant.
        bus_gnt = 1'b0;
        s0 = strobes;
        t0 = tx_count;
        send_read(ADDR_TH);
        wait_req("rst_mid");
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_mid_req", 32'(bus_req), 32'd0);
        check("rst_mid_tx", 32'(uart_tx), 32'd1);
        check("rst_mid_busy", 32'(busy), 32'd0);
        bus_gnt = 1'b1;
        repeat (100) @(negedge clk);
        check("rst_mid_no_strobe", 32'(strobes - s0), 32'd0);
        check("rst_mid_no_reply", 32'(tx_count - t0), 32'd0);

        // Recovery after reset.
        model_read(ADDR_SYSTICK);
        send_read(ADDR_SYSTICK);
        wait_done("recover");
        check("recover_reply", tx_hist, 32'h1234_5678);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
